wam_game_core: RTL and testbench

Parametrised whack-a-mole game engine. It supports a configurable mole count, game length and time base. Moles have a finite lifetime that shortens as the player scores, and a wrong whack costs a point. It drives the mole LEDs and presents score, time remaining and status as binary values to the separate 7-segment display mux. Switch inputs arrive already synchronised and debounced.

---
 rtl/wam_game_core.sv | 236 +++++++++++++++++++++++
 tb/tb_wam_game_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wam_game_core.sv
`default_nettype none
// ============================================================================
// Module   : wam_game_core
// Whack-a-mole engine: game FSM, tick time base, mole timing, scoring.
// Optional high-score register enabled by defining WAM_HIGH_SCORE_EN.
// Revision : 1.0
// ============================================================================
module wam_game_core #(
  parameter int N_MOLES        = 7,
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 10,
  parameter int GAME_SECONDS   = 30,
  parameter int MOLE_TICKS     = 10,
  parameter int MIN_MOLE_TICKS = 3,
  parameter int SPEEDUP_HITS   = 5,
  parameter int SCORE_MAX      = 99
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] switches,
  output logic [N_MOLES-1:0] leds,
  output logic [6:0]         score,
  output logic [6:0]         time_left,
  output logic               playing,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [6:0]         high_score
);

  localparam int c_presc = CLK_HZ / TICK_HZ;
  localparam int c_psw   = (c_presc > 1) ? $clog2(c_presc) : 1;
  localparam int c_tsw   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam int c_posw  = $clog2(N_MOLES);
  localparam int c_lw    = $clog2(MOLE_TICKS + 1);
  localparam int c_hw    = $clog2(SPEEDUP_HITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  typedef enum logic {
    MS_GAP  = 1'b0,
    MS_SHOW = 1'b1
  } mole_state_t;

  game_state_t r_state, w_state_nxt;
  mole_state_t r_mole, w_mole_nxt;

  logic [7:0]         r_lfsr;
  logic               r_start_d;
  logic [N_MOLES-1:0] r_sw_d;
  logic [N_MOLES-1:0] r_toggle;
  logic [c_psw-1:0]   r_presc;
  logic [c_tsw-1:0]   r_tcnt;
  logic               r_primed;
  logic [6:0]         r_score;
  logic [6:0]         r_time;
  logic [c_lw-1:0]    r_life;
  logic [c_lw-1:0]    r_mcnt;
  logic [c_hw-1:0]    r_hits;
  logic [c_posw-1:0]  r_pos;
  logic               r_hit_pulse;
  logic               r_miss_pulse;

  logic               w_start_rise;
  logic               w_go;
  logic               w_in_play;
  logic               w_tick;
  logic               w_mtick;
  logic               w_sec;
  logic               w_last;
  logic [N_MOLES-1:0] w_mask;
  logic               w_showing;
  logic               w_hit;
  logic               w_miss;
  logic [c_posw-1:0]  w_pos_raw;
  logic [c_posw-1:0]  w_pos_sel;
  logic               w_fb;
  logic [6:0]         w_score_nxt;
  logic [c_lw-1:0]    w_life_dec;
  logic               w_show_entry;

  assign w_start_rise = start & ~r_start_d;
  assign w_go         = w_start_rise && (r_state != ST_PLAY);
  assign w_in_play    = (r_state == ST_PLAY);
  assign w_tick       = w_in_play && (r_presc == c_psw'(c_presc - 1));
  // The first tick after entering PLAY only fills the prescaler; mole timing starts after it.
  assign w_mtick      = w_tick && r_primed;
  assign w_sec        = w_tick && (r_tcnt == c_tsw'(TICK_HZ - 1));
  assign w_last       = w_sec && (r_time == 7'd1);
  assign w_mask       = N_MOLES'(1) << r_pos;
  assign w_showing    = w_in_play && (r_mole == MS_SHOW);
  assign w_hit        = w_showing && |(r_toggle & w_mask);
  assign w_miss       = w_showing && !w_hit && |(r_toggle & ~w_mask);
  assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_pos_raw    = c_posw'(r_lfsr % 8'(N_MOLES));
  assign w_pos_sel    = (w_pos_raw != r_pos) ? w_pos_raw :
                        (w_pos_raw == c_posw'(N_MOLES - 1)) ? '0 : w_pos_raw + c_posw'(1);
  assign w_life_dec   = (r_life > c_lw'(MIN_MOLE_TICKS)) ? r_life - c_lw'(1)
                                                         : c_lw'(MIN_MOLE_TICKS);
  assign w_show_entry = (r_mole == MS_GAP) && (w_mole_nxt == MS_SHOW);

  always_comb begin
    w_score_nxt = r_score;
    if (w_hit) begin
      if (r_score < 7'(SCORE_MAX)) w_score_nxt = r_score + 7'd1;
    end else if (w_miss) begin
      if (r_score != 7'd0) w_score_nxt = r_score - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mole  <= MS_GAP;
    end else begin
      r_state <= w_state_nxt;
      r_mole  <= w_mole_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mole_nxt  = r_mole;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_state_nxt = ST_PLAY;
          w_mole_nxt  = MS_GAP;
        end
      end
      ST_PLAY: begin
        if (w_last) w_state_nxt = ST_OVER;
        if (r_mole == MS_GAP) begin
          if (w_mtick) w_mole_nxt = MS_SHOW;
        end else if (w_hit || (w_mtick && (r_mcnt == '0))) begin
          w_mole_nxt = MS_GAP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lfsr       <= 8'h01;
      r_start_d    <= 1'b1;
      r_sw_d       <= '0;
      r_toggle     <= '0;
      r_presc      <= '0;
      r_tcnt       <= '0;
      r_primed     <= 1'b0;
      r_score      <= 7'd0;
      r_time       <= 7'(GAME_SECONDS);
      r_life       <= c_lw'(MOLE_TICKS);
      r_mcnt       <= '0;
      r_hits       <= '0;
      r_pos        <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[6:0], w_fb};
      r_start_d    <= start;
      r_sw_d       <= switches;
      r_toggle     <= switches ^ r_sw_d;
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
      if (w_go) begin
        r_score  <= 7'd0;
        r_time   <= 7'(GAME_SECONDS);
        r_life   <= c_lw'(MOLE_TICKS);
        r_hits   <= '0;
        r_presc  <= '0;
        r_tcnt   <= '0;
        r_primed <= 1'b0;
      end else if (w_in_play) begin
        r_presc <= w_tick ? '0 : r_presc + c_psw'(1);
        r_score <= w_score_nxt;
        if (w_tick) begin
          r_primed <= 1'b1;
          if (w_sec) begin
            r_tcnt <= '0;
            r_time <= r_time - 7'd1;
          end else begin
            r_tcnt <= r_tcnt + c_tsw'(1);
          end
        end
        // Lifetime updates only on a hit, which also ends the current SHOW.
        if (w_hit) begin
          if (r_hits == c_hw'(SPEEDUP_HITS - 1)) begin
            r_hits <= '0;
            r_life <= w_life_dec;
          end else begin
            r_hits <= r_hits + c_hw'(1);
          end
        end
        if (w_show_entry) begin
          r_pos  <= w_pos_sel;
          r_mcnt <= r_life - c_lw'(1);
        end else if ((r_mole == MS_SHOW) && w_mtick && (r_mcnt != '0)) begin
          r_mcnt <= r_mcnt - c_lw'(1);
        end
      end
    end
  end

`ifdef WAM_HIGH_SCORE_EN
  logic [6:0] r_high;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_high <= 7'd0;
    end else if (w_last && (w_score_nxt > r_high)) begin
      r_high <= w_score_nxt;
    end
  end

  assign high_score = r_high;
`else
  assign high_score = 7'd0;
`endif

  assign leds       = w_showing ? w_mask : '0;
  assign score      = r_score;
  assign time_left  = r_time;
  assign playing    = w_in_play;
  assign game_over  = (r_state == ST_OVER);
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;

endmodule
`default_nettype wire

// File: tb/tb_wam_game_core.sv
`default_nettype none
// Directed whack-a-mole scenarios; hit/miss pulses are checked against a queue of expected
// responses by a negedge monitor, timing and state by inline checks.
module tb_wam_game_core;
  localparam int N = 5;

`ifdef WAM_HIGH_SCORE_EN
  localparam int EXP_HS = 3;
`else
  localparam int EXP_HS = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] leds;
  logic [6:0]   score, time_left, high_score;
  logic         playing, game_over, hit_pulse, miss_pulse;

  wam_game_core #(
    .N_MOLES(N), .CLK_HZ(100), .TICK_HZ(10), .GAME_SECONDS(3),
    .MOLE_TICKS(4), .MIN_MOLE_TICKS(2), .SPEEDUP_HITS(2), .SCORE_MAX(99)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .switches(sw),
    .leds(leds), .score(score), .time_left(time_left), .playing(playing),
    .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .high_score(high_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [6:0] score;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   exp_score = 0;
  int   last_pos = -1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  function automatic logic [N-1:0] bit_of(input int i);
    bit_of = '0;
    bit_of[i] = 1'b1;
  endfunction

  function automatic int lit_pos(input logic [N-1:0] l);
    lit_pos = -1;
    for (int i = 0; i < N; i++) if (l[i]) lit_pos = i;
  endfunction

  always @(negedge clk) begin
    if (reset_n && (hit_pulse || miss_pulse)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: hit=%0b miss=%0b score=%0d with nothing queued",
                 hit_pulse, miss_pulse, score);
      end else begin
        mon_e = q.pop_front();
        if (hit_pulse !== mon_e.hit || miss_pulse !== mon_e.miss || score !== mon_e.score) begin
          bad++;
          $display("FAIL pulse_check: got hit=%0b miss=%0b score=%0d, expected hit=%0b miss=%0b score=%0d",
                   hit_pulse, miss_pulse, score, mon_e.hit, mon_e.miss, mon_e.score);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic whack(input logic [N-1:0] m, input logic is_hit);
    sw = sw ^ m;
    if (is_hit) begin
      if (exp_score < 99) exp_score++;
      q.push_back({1'b1, 1'b0, 7'(exp_score)});
    end else begin
      if (exp_score > 0) exp_score--;
      q.push_back({1'b0, 1'b1, 7'(exp_score)});
    end
  endtask

  task automatic note_mole(output int pos);
    pos = lit_pos(leds);
    chk("leds_onehot", $countones(leds), 1);
    if (last_pos >= 0) chk("pos_differs_from_previous", int'(pos == last_pos), 0);
    last_pos = pos;
  endtask

  task automatic wait_mole(output int pos, output int cyc);
    cyc = 0;
    pos = -1;
    while (leds == '0 && cyc < 200) begin
      step(1);
      cyc++;
    end
    if (leds == '0) timeout("wait_mole");
    else note_mole(pos);
  endtask

  task automatic wait_off(output int cyc);
    cyc = 0;
    while (leds != '0 && cyc < 200) begin
      step(1);
      cyc++;
    end
    if (leds != '0) timeout("wait_off");
  endtask

  task automatic wait_over();
    int cyc = 0;
    while (!game_over && cyc < 400) begin
      step(1);
      cyc++;
    end
    if (!game_over) timeout("wait_over");
  endtask

  task automatic hit_next();
    int p, c;
    wait_mole(p, c);
    if (p >= 0) whack(bit_of(p), 1'b1);
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c, w, first_on, first_off;
    logic lit;

    // Reset state
    step(3);
    chk("rst_leds", leds, 0);
    chk("rst_score", score, 0);
    chk("rst_time_left", time_left, 3);
    chk("rst_playing", playing, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
    chk("rst_high_score", high_score, 0);
    reset_n = 1'b1;
    step(2);
    chk("idle_without_start", playing, 0);

    // Game 1: no input, moles escape, clock runs out at 300 cycles
    start = 1'b1;
    step(1);
    chk("start_to_playing", playing, 1);
    start = 1'b0;
    first_on = 0;
    first_off = 0;
    lit = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      step(1);
      if (leds != '0 && !lit) begin
        lit = 1'b1;
        if (first_on == 0) first_on = n;
        note_mole(p);
      end else if (leds == '0 && lit) begin
        lit = 1'b0;
        if (first_off == 0) first_off = n;
      end
      if (n == 99)  chk("time_at_99", time_left, 3);
      if (n == 100) chk("time_at_100", time_left, 2);
      if (n == 200) chk("time_at_200", time_left, 1);
      if (n == 299) chk("over_not_yet_299", {playing, game_over, time_left}, {1'b1, 1'b0, 7'd1});
      if (n == 300) chk("over_at_300", {playing, game_over, time_left, leds},
                        {1'b0, 1'b1, 7'd0, 5'd0});
    end
    chk("g1_first_mole_cycle", first_on, 20);
    chk("g1_lifetime_4_ticks", first_off - first_on, 40);
    chk("g1_score", score, 0);

    // Game 2: hits and lifetime shortening 4 -> 3 -> 2 -> floor 2
    start = 1'b1;
    step(1);
    chk("restart_playing", playing, 1);
    chk("restart_time_left", time_left, 3);
    start = 1'b0;
    exp_score = 0;
    wait_mole(p, c);
    chk("g2_first_mole_cycle", c, 20);
    whack(bit_of(p), 1'b1);
    step(1);
    chk("hit_latency_leds_still_on", leds, bit_of(p));
    chk("hit_latency_no_pulse_yet", hit_pulse, 0);
    step(1);
    chk("hit_clears_leds", leds, 0);
    chk("hit_score_1", score, 1);
    hit_next();
    wait_mole(p, c);
    wait_off(c);
    chk("lifetime_3_ticks", c, 30);
    hit_next();
    hit_next();
    wait_mole(p, c);
    wait_off(c);
    chk("lifetime_2_ticks", c, 20);
    hit_next();
    hit_next();
    wait_mole(p, c);
    wait_off(c);
    chk("lifetime_floor_2_ticks", c, 20);
    wait_over();
    chk("g2_final_score", score, 6);

    // Game 3: misses, saturation at zero, multi-switch miss, hit+miss together
    start = 1'b1;
    step(1);
    start = 1'b0;
    exp_score = 0;
    chk("g3_score_cleared", score, 0);
    hit_next();
    wait_mole(p, c);
    w = (p + 1) % N;
    whack(bit_of(w), 1'b0);
    step(3);
    chk("miss1_score", score, 0);
    chk("miss_mole_stays", leds, bit_of(p));
    whack(bit_of(w), 1'b0);
    step(3);
    chk("miss2_score", score, 0);
    whack(bit_of(w), 1'b0);
    step(3);
    whack(bit_of((p + 1) % N) | bit_of((p + 2) % N), 1'b0);
    step(3);
    whack(bit_of(p) | bit_of((p + 3) % N), 1'b1);
    step(3);
    chk("hit_and_miss_score", score, 1);
    chk("hit_and_miss_leds", leds, 0);

    // Start edge in PLAY ignored; reset mid-game; held start does not retrigger
    start = 1'b1;
    step(5);
    chk("start_in_play_ignored", {playing, score}, {1'b1, 7'd1});
    reset_n = 1'b0;
    step(1);
    chk("midreset_state", {playing, game_over, leds, score, time_left},
        {1'b0, 1'b0, 5'd0, 7'd0, 7'd3});
    chk("midreset_high_score", high_score, 0);
    reset_n = 1'b1;
    exp_score = 0;
    last_pos = -1;
    step(20);
    chk("held_start_no_game", playing, 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("start_after_release", playing, 1);

    // High score: games scoring 3 then 1
    hit_next();
    hit_next();
    hit_next();
    wait_over();
    chk("hsA_score", score, 3);
    chk("hsA_high_score", high_score, EXP_HS);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    exp_score = 0;
    chk("hsB_playing", playing, 1);
    hit_next();
    wait_over();
    chk("hsB_score", score, 1);
    chk("hsB_high_score", high_score, EXP_HS);

    step(4);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
